// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: picks one requesting FU per cycle
// and registers its tag/value as a one-cycle CDB broadcast.
module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int ID_W   = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_FU-1:0]        req,
  input  logic [NUM_FU*ID_W-1:0]   req_id,
  input  logic [NUM_FU*DATA_W-1:0] req_val,
  input  logic                     cdb_hold,
  input  logic                     flush,
  output logic [NUM_FU-1:0]        grant,
  output logic [NUM_FU-1:0]        fu_stall,
  output logic                     cdb_valid,
  output logic [ID_W-1:0]          cdb_id,
  output logic [DATA_W-1:0]        cdb_val
);

  localparam int PTR_W = $clog2(NUM_FU);

  logic [PTR_W-1:0]  r_rr_ptr;
  logic              r_cdb_valid;
  logic [ID_W-1:0]   r_cdb_id;
  logic [DATA_W-1:0] r_cdb_val;

  logic              w_found;
  logic [PTR_W-1:0]  w_gnt_idx;
  logic [PTR_W-1:0]  w_next_ptr;
  logic              w_grant_en;
  logic [NUM_FU-1:0] w_grant;

  // Rotating priority search starting at r_rr_ptr; first hit wins.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] cand;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx  = (int'(r_rr_ptr) + k) % NUM_FU;
      cand = PTR_W'(idx);
      if (!w_found && req[cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = cand;
      end else begin
        w_found   = w_found;
      end
    end
  end

  // Grant is suppressed by reset, flush and back-pressure.
  always_comb begin
    w_grant    = '0;
    w_grant_en = w_found & ~rst & ~flush & ~cdb_hold;
    if (w_grant_en) begin
      w_grant[w_gnt_idx] = 1'b1;
    end else begin
      w_grant = '0;
    end
    if (w_gnt_idx == PTR_W'(NUM_FU - 1)) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = w_gnt_idx + PTR_W'(1);
    end
  end

  // CDB broadcast registers and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_id    <= '0;
      r_cdb_val   <= '0;
    end else if (flush) begin
      r_cdb_valid <= 1'b0;
      r_cdb_id    <= '0;
      r_cdb_val   <= '0;
    end else if (cdb_hold) begin
      r_cdb_valid <= r_cdb_valid;
    end else if (w_grant_en) begin
      r_cdb_valid <= 1'b1;
      r_cdb_id    <= req_id[int'(w_gnt_idx)*ID_W +: ID_W];
      r_cdb_val   <= req_val[int'(w_gnt_idx)*DATA_W +: DATA_W];
      r_rr_ptr    <= w_next_ptr;
    end else begin
      // Idle: tag/value keep their last contents, only valid drops.
      r_cdb_valid <= 1'b0;
    end
  end

  assign grant     = w_grant;
  assign fu_stall  = req & ~w_grant;
  assign cdb_valid = r_cdb_valid;
  assign cdb_id    = r_cdb_id;
  assign cdb_val   = r_cdb_val;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a reference model predicts grants and the
// next-cycle CDB contents, which are queued and compared after each clock edge.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_id;
  logic [31:0] req_val;
  logic        cdb_hold;
  logic        flush;
  logic [3:0]  grant;
  logic [3:0]  fu_stall;
  logic        cdb_valid;
  logic [3:0]  cdb_id;
  logic [7:0]  cdb_val;

  typedef struct packed {
    logic       v;
    logic [3:0] id;
    logic [7:0] val;
  } cdb_t;

  cdb_t       sb_q[$];
  logic [1:0] m_ptr;
  cdb_t       m_cdb;
  logic [3:0] last_grant;
  int         n_checks = 0;
  int         n_fail   = 0;

  cdb_arbiter #(.NUM_FU(4), .ID_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_id(req_id), .req_val(req_val),
    .cdb_hold(cdb_hold), .flush(flush), .grant(grant), .fu_stall(fu_stall),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_grant(input logic [3:0] r, input logic [1:0] p,
                                             input logic h, input logic f);
    int idx;
    if (h || f) return 4'b0000;
    for (int k = 0; k < 4; k++) begin
      idx = (int'(p) + k) % 4;
      if (r[idx]) return 4'(1 << idx);
    end
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_ptr = 2'd0;
    m_cdb = '0;
    sb_q.delete();
  endtask

  // One clock cycle: drive at negedge, check comb outputs, predict, then compare after edge.
  task automatic cycle(input logic [3:0] r, input logic [15:0] ids, input logic [31:0] vals,
                       input logic h, input logic f);
    logic [3:0] eg;
    cdb_t       exp;
    req = r; req_id = ids; req_val = vals; cdb_hold = h; flush = f;
    #1;
    eg = model_grant(r, m_ptr, h, f);
    check("grant", 32'(grant), 32'(eg));
    check("fu_stall", 32'(fu_stall), 32'(r & ~eg));
    last_grant = grant;
    if (f) begin
      m_cdb = '0;
    end else if (h) begin
      m_cdb = m_cdb;
    end else if (eg != 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        if (eg[i]) begin
          m_cdb.v   = 1'b1;
          m_cdb.id  = ids[i*4 +: 4];
          m_cdb.val = vals[i*8 +: 8];
          m_ptr     = 2'((i + 1) % 4);
        end
      end
    end else begin
      m_cdb.v = 1'b0;
    end
    sb_q.push_back(m_cdb);
    @(posedge clk);
    @(negedge clk);
    exp = sb_q.pop_front();
    check("cdb_valid", 32'(cdb_valid), 32'(exp.v));
    check("cdb_id", 32'(cdb_id), 32'(exp.id));
    check("cdb_val", 32'(cdb_val), 32'(exp.val));
  endtask

  localparam logic [15:0] IDS_A  = {4'd4, 4'd3, 4'd2, 4'd1};
  localparam logic [31:0] VALS_A = {8'h44, 8'h33, 8'h22, 8'h11};
  localparam logic [15:0] IDS_H  = {4'd4, 4'd3, 4'd2, 4'd5};
  localparam logic [31:0] VALS_H = {8'h44, 8'h33, 8'h22, 8'hA5};
  localparam logic [15:0] IDS_F  = {4'd4, 4'd3, 4'd6, 4'd1};
  localparam logic [31:0] VALS_F = {8'h44, 8'h33, 8'h3C, 8'h11};

  initial begin
    logic [3:0] rr_seq [5];
    rr_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    rst = 1'b1; req = 4'b1111; req_id = IDS_A; req_val = VALS_A;
    cdb_hold = 1'b0; flush = 1'b0;
    model_reset();

    // Reset state
    #2;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_stall", 32'(fu_stall), 32'hF);
    check("rst_valid", 32'(cdb_valid), 32'h0);
    check("rst_id", 32'(cdb_id), 32'h0);
    check("rst_val", 32'(cdb_val), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Round robin with everyone requesting
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, IDS_A, VALS_A, 1'b0, 1'b0);
      check("rr_id_seq", 32'(cdb_id), 32'(rr_seq[i]));
      check("rr_stall3", 32'($countones(fu_stall)), 32'd3);
    end

    // Wrap: bring pointer to 3, then only FU0/FU1 request
    cycle(4'b0100, IDS_A, VALS_A, 1'b0, 1'b0);
    cycle(4'b0011, IDS_A, VALS_A, 1'b0, 1'b0);
    check("wrap_g0", 32'(last_grant), 32'h1);
    cycle(4'b0010, IDS_A, VALS_A, 1'b0, 1'b0);
    check("wrap_g1", 32'(last_grant), 32'h2);
    cycle(4'b1111, IDS_A, VALS_A, 1'b0, 1'b0);
    check("wrap_ptr2", 32'(last_grant), 32'h4);

    // Hold freezes an active broadcast
    cycle(4'b0001, IDS_H, VALS_H, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0100, IDS_H, VALS_H, 1'b1, 1'b0);
      check("hold_grant0", 32'(last_grant), 32'h0);
      check("hold_id", 32'(cdb_id), 32'h5);
      check("hold_val", 32'(cdb_val), 32'hA5);
      check("hold_valid", 32'(cdb_valid), 32'h1);
    end
    cycle(4'b0100, IDS_H, VALS_H, 1'b0, 1'b0);
    check("hold_release", 32'(last_grant), 32'h4);

    // Flush kills the broadcast and leaves the pointer alone
    cycle(4'b0010, IDS_F, VALS_F, 1'b0, 1'b0);
    check("flush_pre_val", 32'(cdb_val), 32'h3C);
    cycle(4'b1000, IDS_F, VALS_F, 1'b0, 1'b1);
    check("flush_valid", 32'(cdb_valid), 32'h0);
    check("flush_val", 32'(cdb_val), 32'h0);
    cycle(4'b1100, IDS_F, VALS_F, 1'b0, 1'b0);
    check("flush_ptr", 32'(last_grant), 32'h4);
    cycle(4'b0000, IDS_F, VALS_F, 1'b1, 1'b1);
    check("flush_hold_valid", 32'(cdb_valid), 32'h0);
    check("flush_hold_id", 32'(cdb_id), 32'h0);
    cycle(4'b1111, IDS_F, VALS_F, 1'b0, 1'b0);
    check("flush_hold_ptr", 32'(last_grant), 32'h8);

    // Single requester granted every cycle
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0100, IDS_A, VALS_A, 1'b0, 1'b0);
      check("single_grant", 32'(last_grant), 32'h4);
      check("single_valid", 32'(cdb_valid), 32'h1);
    end

    // Asynchronous reset in the middle of a broadcast
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(cdb_valid), 32'h0);
    check("arst_id", 32'(cdb_id), 32'h0);
    check("arst_grant", 32'(grant), 32'h0);
    check("arst_stall", 32'(fu_stall), 32'h4);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(4'b0110, IDS_A, VALS_A, 1'b0, 1'b0);
    check("arst_ptr0", 32'(last_grant), 32'h2);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      cycle(4'($urandom_range(0, 15)), 16'($urandom), $urandom,
            ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
